// File: rtl/aes_byte_stream_loader.sv
// ---------------------------------------------------------------------------
// aes_byte_stream_loader
//
// Byte-serial wrapper around a 128-bit combinational AES core. A transaction
// loads 16 key bytes and then 16 plaintext bytes over an 8-bit valid/ready
// stream. It then waits CORE_LAT cycles for the core to settle, captures the
// 128-bit result, and streams the result back out as 16 bytes. Input and
// output never overlap.
//
// Parameters
//   CORE_LAT  : cycles from the last input handshake to result capture (>=1)
//   MSB_FIRST : 1 -> byte 0 is bits [127:120]; 0 -> byte 0 is bits [7:0]
//
// Ports
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_data    : input byte stream
//   in_mode                      : sampled with byte 0 (1 = encrypt, 0 = round trip)
//   out_valid/out_ready/out_data : output byte stream
//   out_last                     : marks the 16th output byte
//   core_key/core_text/core_flag : registers feeding the AES core
//   core_result                  : AES core output
//   busy                         : first input byte through last output byte
//
// Optional feature (macro AES_KEY_REUSE_EN)
//   Adds input key_reuse. When it is high on the first handshake of a
//   transaction, that byte is plaintext byte 0 and the previous key is kept,
//   giving a 16-byte transaction.
// ---------------------------------------------------------------------------
module aes_byte_stream_loader #(
  parameter int CORE_LAT  = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_mode,
`ifdef AES_KEY_REUSE_EN
  input  logic         key_reuse,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic [127:0] core_key,
  output logic [127:0] core_text,
  output logic         core_flag,
  input  logic [127:0] core_result,
  output logic         busy
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;

  localparam int          SW          = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(CORE_LAT - 1);

  logic [1:0]    state_q,  state_d;
  logic [4:0]    cnt_q,    cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [127:0]  key_q,    key_d;
  logic [127:0]  text_q,   text_d;
  logic [127:0]  result_q, result_d;
  logic          flag_q,   flag_d;
  logic          busy_q,   busy_d;

  logic          in_hs;
  logic          out_hs;
  logic          reuse_now;
  logic [4:0]    byte_idx;
  logic [3:0]    wr_lane;
  logic [3:0]    rd_lane;

  // A key-reuse transaction starts writing at plaintext byte 0 (index 16).
`ifdef AES_KEY_REUSE_EN
  assign reuse_now = key_reuse && (cnt_q == 5'd0);
`else
  assign reuse_now = 1'b0;
`endif

  assign in_hs    = in_valid && (state_q == ST_LOAD);
  assign out_hs   = out_ready && (state_q == ST_SEND);
  assign byte_idx = reuse_now ? 5'd16 : cnt_q;

  // Stream byte position -> 8-bit lane within the 128-bit word.
  assign wr_lane = MSB_FIRST ? (4'd15 - byte_idx[3:0]) : byte_idx[3:0];
  assign rd_lane = MSB_FIRST ? (4'd15 - cnt_q[3:0])    : cnt_q[3:0];

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned; that is what keeps always_comb free of latches.
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    key_d    = key_q;
    text_d   = text_q;
    result_d = result_q;
    flag_d   = flag_q;
    busy_d   = busy_q;

    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          if (byte_idx[4]) text_d[{wr_lane, 3'b000} +: 8] = in_data;
          else             key_d[{wr_lane, 3'b000} +: 8]  = in_data;

          if (cnt_q == 5'd0) begin
            flag_d = in_mode;
            busy_d = 1'b1;
          end

          if (byte_idx == 5'd31) begin
            state_d  = ST_SETTLE;
            cnt_d    = 5'd0;
            settle_d = '0;
          end else begin
            cnt_d = byte_idx + 5'd1;
          end
        end
      end

      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          result_d = core_result;
          settle_d = '0;
          state_d  = ST_SEND;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_SEND: begin
        if (out_hs) begin
          if (cnt_q == 5'd15) begin
            state_d = ST_LOAD;
            cnt_d   = 5'd0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= ST_LOAD;
      cnt_q    <= 5'd0;
      settle_q <= '0;
      key_q    <= '0;
      text_q   <= '0;
      result_q <= '0;
      flag_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      key_q    <= key_d;
      text_q   <= text_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      busy_q   <= busy_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_SEND);
  assign out_data  = out_valid ? result_q[{rd_lane, 3'b000} +: 8] : 8'h00;
  assign out_last  = out_valid && (cnt_q == 5'd15);
  assign core_key  = key_q;
  assign core_text = text_q;
  assign core_flag = flag_q;
  assign busy      = busy_q;

endmodule
